// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the calculator keypad controller.
//   - keycode values, FSM state encoding, opsel encoding
//   - DIGMAX (digits per operand) and TIMEOUT (CALC watchdog limit)
//   - small keycode classification helpers
package calc_pkg;

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_SUB = 5'h11;
  localparam logic [4:0] K_MUL = 5'h12;
  localparam logic [4:0] K_EQ  = 5'h13;
  localparam logic [4:0] K_BS  = 5'h14;
  localparam logic [4:0] K_CLR = 5'h15;

  localparam int DIGMAX  = 4;
  localparam int TIMEOUT = 255;

  typedef enum logic [2:0] {
    S_ENTRY1 = 3'd0,
    S_OPWAIT = 3'd1,
    S_ENTRY2 = 3'd2,
    S_CALC   = 3'd3,
    S_RESULT = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } opsel_t;

  // Hex digits occupy 0x00-0x0F, i.e. bit 4 clear.
  function automatic logic is_digit(input logic [4:0] k);
    return (k[4] == 1'b0);
  endfunction

  function automatic logic is_op(input logic [4:0] k);
    return (k == K_ADD) || (k == K_SUB) || (k == K_MUL);
  endfunction

endpackage

// File: rtl/calc_watchdog.sv
// calc_watchdog: 8-bit cycle counter guarding the ALU handshake.
//   i_clock, i_reset : clock, async active-high reset
//   i_clr            : synchronous clear (priority over enable)
//   i_en             : count this cycle
//   o_expired        : high on the TIMEOUT-th enabled cycle since clear
module calc_watchdog
  import calc_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)    r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 8'd1;
  end

  // Fires on the edge that completes the TIMEOUT-th counted cycle, so the
  // owner leaves its wait state exactly TIMEOUT cycles after entering it.
  assign o_expired = i_en && (r_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/calc_control.sv
// calc_control: keypad-driven control FSM for a 4-digit hex calculator.
//   clock, reset     : clock, async active-high reset
//   keyvalid/keycode : one-cycle key strobe and its code
//   aludone          : ALU completion strobe (honoured only in CALC)
//   newhex/hexcode   : shift a digit into the current operand
//   newop, eq, BS, clr, alustart : one-cycle command pulses
//   opsel            : latched operation (0 add, 1 sub, 2 mul)
//   busy / err       : in CALC / in ERROR
// All pulses are registered: they appear one clock after the sampled input.
module calc_control
  import calc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       keyvalid,
  input  logic [4:0] keycode,
  input  logic       aludone,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic       eq,
  output logic       BS,
  output logic       clr,
  output logic [1:0] opsel,
  output logic       alustart,
  output logic       busy,
  output logic       err
);

  state_t     r_state, w_state;
  logic [2:0] r_dcnt, w_dcnt;
  opsel_t     r_opsel, w_opsel;
  logic       r_newhex, w_newhex;
  logic [3:0] r_hexcode, w_hexcode;
  logic       r_newop, w_newop, r_eq, w_eq, r_bs, w_bs;
  logic       r_clr, w_clr, r_alustart, w_alustart;
  logic       w_wd_expired;

  wire w_digit = keyvalid && is_digit(keycode);
  wire w_op    = keyvalid && is_op(keycode);
  wire w_eqkey = keyvalid && (keycode == K_EQ);
  wire w_bskey = keyvalid && (keycode == K_BS);
  wire w_clear = keyvalid && (keycode == K_CLR);

  // Held clear outside CALC so every CALC visit starts from zero.
  calc_watchdog u_wd (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_clr     (r_state != S_CALC),
    .i_en      (r_state == S_CALC),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_ENTRY1;
      r_dcnt     <= '0;
      r_opsel    <= OP_ADD;
      r_newhex   <= 1'b0;
      r_hexcode  <= '0;
      r_newop    <= 1'b0;
      r_eq       <= 1'b0;
      r_bs       <= 1'b0;
      r_clr      <= 1'b0;
      r_alustart <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_dcnt     <= w_dcnt;
      r_opsel    <= w_opsel;
      r_newhex   <= w_newhex;
      r_hexcode  <= w_hexcode;
      r_newop    <= w_newop;
      r_eq       <= w_eq;
      r_bs       <= w_bs;
      r_clr      <= w_clr;
      r_alustart <= w_alustart;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_dcnt     = r_dcnt;
    w_opsel    = r_opsel;
    w_newhex   = 1'b0;
    w_hexcode  = '0;
    w_newop    = 1'b0;
    w_eq       = 1'b0;
    w_bs       = 1'b0;
    w_clr      = 1'b0;
    w_alustart = 1'b0;

    // Clear overrides everything, including a pending aludone in CALC.
    if (w_clear) begin
      w_clr   = 1'b1;
      w_dcnt  = '0;
      w_opsel = OP_ADD;
      w_state = S_ENTRY1;
    end else begin
      case (r_state)
        S_ENTRY1, S_ENTRY2: begin
          if (w_digit && (r_dcnt < 3'(DIGMAX))) begin
            w_newhex  = 1'b1;
            w_hexcode = keycode[3:0];
            w_dcnt    = r_dcnt + 3'd1;
          end else if (w_bskey && (r_dcnt != '0)) begin
            w_bs   = 1'b1;
            w_dcnt = r_dcnt - 3'd1;
          end else if (w_op && (r_state == S_ENTRY1)) begin
            w_newop = 1'b1;
            w_opsel = opsel_t'(keycode[1:0]);
            w_dcnt  = '0;
            w_state = S_OPWAIT;
          end else if (w_eqkey && (r_state == S_ENTRY2)) begin
            w_alustart = 1'b1;
            w_state    = S_CALC;
          end
        end
        S_OPWAIT: begin
          if (w_digit) begin
            w_newhex  = 1'b1;
            w_hexcode = keycode[3:0];
            w_dcnt    = 3'd1;
            w_state   = S_ENTRY2;
          end else if (w_op) begin
            w_opsel = opsel_t'(keycode[1:0]);
          end
        end
        S_CALC: begin
          // aludone beats a coincident timeout.
          if (aludone) begin
            w_eq    = 1'b1;
            w_state = S_RESULT;
          end else if (w_wd_expired) begin
            w_state = S_ERROR;
          end
        end
        S_RESULT: begin
          if (w_op) begin
            w_newop = 1'b1;
            w_opsel = opsel_t'(keycode[1:0]);
            w_dcnt  = '0;
            w_state = S_OPWAIT;
          end else if (w_digit) begin
            // Starting a fresh V1: wipe the old result and shift in the digit.
            w_clr     = 1'b1;
            w_newhex  = 1'b1;
            w_hexcode = keycode[3:0];
            w_dcnt    = 3'd1;
            w_state   = S_ENTRY1;
          end
        end
        default: ; // S_ERROR: only clear escapes
      endcase
    end
  end

  assign newhex   = r_newhex;
  assign hexcode  = r_hexcode;
  assign newop    = r_newop;
  assign eq       = r_eq;
  assign BS       = r_bs;
  assign clr      = r_clr;
  assign opsel    = r_opsel;
  assign alustart = r_alustart;
  // Decoded straight from the state register, so still glitch-free and
  // reset to 0 asynchronously with it.
  assign busy     = (r_state == S_CALC);
  assign err      = (r_state == S_ERROR);

endmodule

// File: tb/tb_calc_control.sv
module tb_calc_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       keyvalid, aludone;
  logic [4:0] keycode;
  logic       newhex, newop, eq, BS, clr, alustart, busy, err;
  logic [3:0] hexcode;
  logic [1:0] opsel;

  always #5 clock = ~clock;

  calc_control dut (
    .clock(clock), .reset(reset), .keyvalid(keyvalid), .keycode(keycode),
    .aludone(aludone), .newhex(newhex), .hexcode(hexcode), .newop(newop),
    .eq(eq), .BS(BS), .clr(clr), .opsel(opsel), .alustart(alustart),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic       newhex;
    logic [3:0] hexcode;
    logic       newop;
    logic       eq;
    logic       bs;
    logic       clr;
    logic [1:0] opsel;
    logic       alustart;
    logic       busy;
    logic       err;
  } outs_t;

  typedef struct {
    logic       kv;
    logic [4:0] kc;
    logic       ad;
    outs_t      exp;
  } vec_t;

  outs_t got;
  assign got = {newhex, hexcode, newop, eq, BS, clr, opsel, alustart, busy, err};

  int nvec = 0;
  int nbad = 0;

  // ---------------- behavioural reference model ----------------
  // Phase of the calculation plus the digits of the operand being typed.
  localparam int P_V1 = 0, P_WAITV2 = 1, P_V2 = 2, P_ALU = 3, P_ANS = 4, P_DEAD = 5;
  int         ph;
  logic [3:0] cur[$];
  int         alu_cycles;
  logic [1:0] m_op;
  outs_t      exp_o;

  task automatic model_reset();
    ph = P_V1; cur.delete(); alu_cycles = 0; m_op = 2'd0; exp_o = '0;
  endtask

  task automatic model_step(input logic kv, input logic [4:0] kc, input logic ad);
    bit dig, opk;
    dig = kv && (kc < 5'h10);
    opk = kv && (kc >= 5'h10) && (kc <= 5'h12);
    exp_o = '0;
    if (kv && kc == 5'h15) begin
      ph = P_V1; cur.delete(); m_op = 2'd0; exp_o.clr = 1'b1;
    end else begin
      case (ph)
        P_V1, P_V2: begin
          if (dig) begin
            if (cur.size() < 4) begin
              cur.push_back(kc[3:0]); exp_o.newhex = 1'b1; exp_o.hexcode = kc[3:0];
            end
          end else if (kv && kc == 5'h14) begin
            if (cur.size() > 0) begin void'(cur.pop_back()); exp_o.bs = 1'b1; end
          end else if (opk && ph == P_V1) begin
            exp_o.newop = 1'b1; m_op = 2'(kc - 5'h10); cur.delete(); ph = P_WAITV2;
          end else if (kv && kc == 5'h13 && ph == P_V2) begin
            exp_o.alustart = 1'b1; alu_cycles = 0; ph = P_ALU;
          end
        end
        P_WAITV2: begin
          if (dig) begin
            cur.delete(); cur.push_back(kc[3:0]);
            exp_o.newhex = 1'b1; exp_o.hexcode = kc[3:0]; ph = P_V2;
          end else if (opk) m_op = 2'(kc - 5'h10);
        end
        P_ALU: begin
          if (ad) begin exp_o.eq = 1'b1; ph = P_ANS; end
          else begin
            alu_cycles++;
            if (alu_cycles == 255) ph = P_DEAD;
          end
        end
        P_ANS: begin
          if (opk) begin
            exp_o.newop = 1'b1; m_op = 2'(kc - 5'h10); cur.delete(); ph = P_WAITV2;
          end else if (dig) begin
            cur.delete(); cur.push_back(kc[3:0]);
            exp_o.clr = 1'b1; exp_o.newhex = 1'b1; exp_o.hexcode = kc[3:0]; ph = P_V1;
          end
        end
        default: ;
      endcase
    end
    exp_o.opsel = m_op;
    exp_o.busy  = (ph == P_ALU);
    exp_o.err   = (ph == P_DEAD);
  endtask

  // ---------------- drivers / checkers ----------------
  task automatic check(input string nm, input outs_t e);
    nvec++;
    if (got !== e) begin
      nbad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, e, $time);
    end
  endtask

  task automatic check_bit(input string nm, input logic a, input logic e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic step(input string nm, input logic kv, input logic [4:0] kc, input logic ad);
    keyvalid = kv; keycode = kc; aludone = ad;
    @(posedge clock);
    model_step(kv, kc, ad);
    #1;
    keyvalid = 1'b0; aludone = 1'b0;
    check(nm, exp_o);
  endtask

  task automatic key(input string nm, input logic [4:0] kc);
    step(nm, 1'b1, kc, 1'b0);
  endtask

  task automatic idle(input string nm, input int n);
    for (int i = 0; i < n; i++) step(nm, 1'b0, 5'h00, 1'b0);
  endtask

  function automatic outs_t mk(input logic nh, input logic [3:0] hx, input logic nop,
                               input logic e, input logic b, input logic c,
                               input logic [1:0] op, input logic as, input logic by);
    outs_t o;
    o = '{newhex: nh, hexcode: hx, newop: nop, eq: e, bs: b, clr: c,
          opsel: op, alustart: as, busy: by, err: 1'b0};
    return o;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    check("reset_state", '0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  vec_t tbl[12];
  int   cnt_nh, cnt_bs, cnt_nop;

  initial begin
    reset = 1'b1; keyvalid = 1'b0; keycode = '0; aludone = 1'b0;
    model_reset();

    // Basic transaction 3 2 + 1 1 = with aludone on the fifth CALC cycle.
    tbl[0]  = '{1'b1, 5'h03, 1'b0, mk(1, 4'h3, 0, 0, 0, 0, 2'd0, 0, 0)};
    tbl[1]  = '{1'b1, 5'h02, 1'b0, mk(1, 4'h2, 0, 0, 0, 0, 2'd0, 0, 0)};
    tbl[2]  = '{1'b1, 5'h10, 1'b0, mk(0, 4'h0, 1, 0, 0, 0, 2'd0, 0, 0)};
    tbl[3]  = '{1'b1, 5'h01, 1'b0, mk(1, 4'h1, 0, 0, 0, 0, 2'd0, 0, 0)};
    tbl[4]  = '{1'b1, 5'h01, 1'b0, mk(1, 4'h1, 0, 0, 0, 0, 2'd0, 0, 0)};
    tbl[5]  = '{1'b1, 5'h13, 1'b0, mk(0, 4'h0, 0, 0, 0, 0, 2'd0, 1, 1)};
    tbl[6]  = '{1'b0, 5'h00, 1'b0, mk(0, 4'h0, 0, 0, 0, 0, 2'd0, 0, 1)};
    tbl[7]  = '{1'b1, 5'h07, 1'b0, mk(0, 4'h0, 0, 0, 0, 0, 2'd0, 0, 1)};
    tbl[8]  = '{1'b0, 5'h00, 1'b0, mk(0, 4'h0, 0, 0, 0, 0, 2'd0, 0, 1)};
    tbl[9]  = '{1'b0, 5'h00, 1'b0, mk(0, 4'h0, 0, 0, 0, 0, 2'd0, 0, 1)};
    tbl[10] = '{1'b0, 5'h00, 1'b1, mk(0, 4'h0, 0, 1, 0, 0, 2'd0, 0, 0)};
    tbl[11] = '{1'b1, 5'h13, 1'b0, mk(0, 4'h0, 0, 0, 0, 0, 2'd0, 0, 0)};

    do_reset();
    foreach (tbl[i]) begin
      keyvalid = tbl[i].kv; keycode = tbl[i].kc; aludone = tbl[i].ad;
      @(posedge clock);
      model_step(tbl[i].kv, tbl[i].kc, tbl[i].ad);
      #1;
      keyvalid = 1'b0; aludone = 1'b0;
      check($sformatf("tbl[%0d]", i), tbl[i].exp);
    end
    // Still in RESULT: a digit restarts V1 with clr+newhex together.
    key("result_digit", 5'h09);
    check_bit("result_digit_clr", clr, 1'b1);
    check_bit("result_digit_hex9", hexcode == 4'h9, 1'b1);

    // Digit limit and backspace floor.
    do_reset();
    cnt_nh = 0; cnt_bs = 0;
    for (int i = 0; i < 5; i++) begin
      key("dig_limit", (i == 4) ? 5'h07 : 5'h05);
      cnt_nh += newhex;
    end
    for (int i = 0; i < 5; i++) begin
      key("bs_floor", 5'h14);
      cnt_bs += BS;
    end
    check_bit("newhex_count4", cnt_nh == 4, 1'b1);
    check_bit("bs_count4", cnt_bs == 4, 1'b1);

    // Op relatch in OPWAIT, equals ignored there.
    do_reset();
    cnt_nop = 0;
    key("v1", 5'h0A);
    key("sub", 5'h11); cnt_nop += newop;
    key("mul", 5'h12); cnt_nop += newop;
    key("eq_opwait", 5'h13);
    check_bit("opwait_no_alustart", alustart, 1'b0);
    check_bit("one_newop", cnt_nop == 1, 1'b1);
    check_bit("opsel_mul", opsel == 2'd2, 1'b1);
    key("op_in_entry2", 5'h0B);
    key("op_in_entry2", 5'h10);  // ignored in ENTRY2

    // Watchdog timeout, ERROR lock, clear recovery.
    key("eq", 5'h13);
    idle("calc_wait", 254);
    check_bit("no_err_before_255", err, 1'b0);
    idle("calc_timeout", 1);
    check_bit("err_at_255", err, 1'b1);
    key("err_digit", 5'h04);
    key("err_clear", 5'h15);
    check_bit("clear_clr", clr, 1'b1);
    check_bit("clear_err0", err, 1'b0);

    // Chaining from RESULT, then aludone coinciding with the timeout.
    key("c1", 5'h01); key("c+", 5'h10); key("c2", 5'h02); key("c=", 5'h13);
    step("c_done", 1'b0, 5'h00, 1'b1);
    key("chain_add", 5'h10);
    check_bit("chain_newop", newop, 1'b1);
    key("chain_v2", 5'h03);
    key("chain_eq", 5'h13);
    idle("race_wait", 254);
    step("race_aludone", 1'b0, 5'h00, 1'b1);
    check_bit("race_eq_wins", eq, 1'b1);
    step("stray_aludone", 1'b0, 5'h00, 1'b1);  // outside CALC
    key("undef_code", 5'h1E);

    // Async reset mid-CALC.
    key("r1", 5'h01); key("r+", 5'h10); key("r2", 5'h02); key("r=", 5'h13);
    idle("r_calc", 3);
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_outs", '0);
    @(posedge clock); #1;
    reset = 1'b0;
    step("post_reset_aludone", 1'b0, 5'h00, 1'b1);
    key("first_key_after_reset", 5'h0C);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic       kv, ad;
      logic [4:0] kc;
      kv = ($urandom_range(0, 1) == 1);
      ad = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 60) == 0)      kc = 5'h15;
      else if ($urandom_range(0, 9) == 0)  kc = 5'($urandom_range(0, 31));
      else                                 kc = 5'($urandom_range(0, 20));
      step("random", kv, kc, ad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
